// File: rtl/imm_field_encoder.sv
// Packs a signed immediate into the I/S/B/U/J fields of a base instruction word and
// queues the result in a 2-entry FIFO. Define IMM_RANGE_CHECK_EN to flag range/alignment/type errors.
module imm_field_encoder (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [2:0]  IMM_TYPE,
    input  logic [31:0] IMM_VALUE,
    input  logic [31:0] BASE_INSTR,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] INSTRUCTION,
    output logic        IMM_ERR
);
    localparam logic [2:0] TYPE_I = 3'd0;
    localparam logic [2:0] TYPE_S = 3'd1;
    localparam logic [2:0] TYPE_B = 3'd2;
    localparam logic [2:0] TYPE_U = 3'd3;
    localparam logic [2:0] TYPE_J = 3'd4;

    logic [31:0] mem_word [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [31:0] enc_word;
    logic        push;
    logic        pop;

    always_comb begin
        enc_word = BASE_INSTR;
        case (IMM_TYPE)
            TYPE_I: enc_word = {IMM_VALUE[11:0], BASE_INSTR[19:0]};
            TYPE_S: enc_word = {IMM_VALUE[11:5], BASE_INSTR[24:12], IMM_VALUE[4:0], BASE_INSTR[6:0]};
            TYPE_B: enc_word = {IMM_VALUE[12], IMM_VALUE[10:5], BASE_INSTR[24:12],
                                IMM_VALUE[4:1], IMM_VALUE[11], BASE_INSTR[6:0]};
            TYPE_U: enc_word = {IMM_VALUE[31:12], BASE_INSTR[11:0]};
            TYPE_J: enc_word = {IMM_VALUE[20], IMM_VALUE[10:1], IMM_VALUE[11],
                                IMM_VALUE[19:12], BASE_INSTR[11:0]};
            default: enc_word = BASE_INSTR;
        endcase
    end

    // Ready depends on registered occupancy only, so OUT_READY never reaches IN_READY.
    assign IN_READY    = (count != 2'd2);
    assign OUT_VALID   = (count != 2'd0);
    assign push        = IN_VALID && IN_READY;
    assign pop         = OUT_VALID && OUT_READY;
    assign INSTRUCTION = mem_word[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem_word[0] <= '0;
            mem_word[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                mem_word[wr_ptr] <= enc_word;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    logic mem_err [2];
    logic enc_err;

    // A value fits an N-bit signed field when every bit from N-1 upward matches the sign.
    always_comb begin
        enc_err = 1'b0;
        case (IMM_TYPE)
            TYPE_I, TYPE_S: enc_err = !((&IMM_VALUE[31:11]) || !(|IMM_VALUE[31:11]));
            TYPE_B:         enc_err = !((&IMM_VALUE[31:12]) || !(|IMM_VALUE[31:12])) || IMM_VALUE[0];
            TYPE_U:         enc_err = |IMM_VALUE[11:0];
            TYPE_J:         enc_err = !((&IMM_VALUE[31:20]) || !(|IMM_VALUE[31:20])) || IMM_VALUE[0];
            default:        enc_err = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem_err[0] <= 1'b0;
            mem_err[1] <= 1'b0;
        end else if (push) begin
            mem_err[wr_ptr] <= enc_err;
        end
    end

    assign IMM_ERR = mem_err[rd_ptr];
`else
    assign IMM_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_imm_field_encoder.sv
// Scoreboard bench for imm_field_encoder: directed corner jobs plus randomized traffic
// with random back-pressure, checked against a field-level reference model.
module tb_imm_field_encoder;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [2:0]  IMM_TYPE;
    logic [31:0] IMM_VALUE;
    logic [31:0] BASE_INSTR;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] INSTRUCTION;
    logic        IMM_ERR;

    int tests  = 0;
    int errors = 0;
    logic [32:0] exp_q [$];
    bit random_phase = 0;

    imm_field_encoder dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IMM_TYPE(IMM_TYPE), .IMM_VALUE(IMM_VALUE), .BASE_INSTR(BASE_INSTR),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .INSTRUCTION(INSTRUCTION),
        .IMM_ERR(IMM_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Reference: place immediate bits field by field, then decide legality numerically.
    function automatic logic [32:0] model(input logic [2:0] t, input logic [31:0] v, input logic [31:0] b);
        logic [31:0] w;
        logic        e;
        longint      sv;
        w  = b;
        sv = longint'($signed(v));
        e  = 1'b0;
        case (t)
            3'd0: begin
                for (int i = 0; i < 12; i++) w[20+i] = v[i];
                e = (sv < -2048) || (sv > 2047);
            end
            3'd1: begin
                for (int i = 0; i < 5; i++) w[7+i] = v[i];
                for (int i = 5; i < 12; i++) w[20+i] = v[i];
                e = (sv < -2048) || (sv > 2047);
            end
            3'd2: begin
                w[31] = v[12];
                w[7]  = v[11];
                for (int i = 5; i < 11; i++) w[20+i] = v[i];
                for (int i = 1; i < 5; i++) w[7+i] = v[i];
                e = (sv < -4096) || (sv > 4094) || (sv % 2 != 0);
            end
            3'd3: begin
                for (int i = 12; i < 32; i++) w[i] = v[i];
                e = (v % 4096) != 0;
            end
            3'd4: begin
                w[31] = v[20];
                w[20] = v[11];
                for (int i = 1; i < 11; i++) w[20+i] = v[i];
                for (int i = 12; i < 20; i++) w[i] = v[i];
                e = (sv < -1048576) || (sv > 1048574) || (sv % 2 != 0);
            end
            default: e = 1'b1;
        endcase
`ifndef IMM_RANGE_CHECK_EN
        e = 1'b0;
`endif
        return {e, w};
    endfunction

    // Inputs change at posedge+1; at the negedge a handshake about to complete is visible.
    task automatic send(input logic [2:0] t, input logic [31:0] v, input logic [31:0] b);
        int n;
        IN_VALID = 1'b1; IMM_TYPE = t; IMM_VALUE = v; BASE_INSTR = b;
        n = 0;
        @(negedge CLK);
        while (!IN_READY && n < 500) begin
            n++;
            @(negedge CLK);
        end
        if (!IN_READY) begin
            tests++; errors++;
            $display("FAIL send_timeout: IN_READY stayed 0, expected 1 within 500 cycles");
        end else begin
            exp_q.push_back(model(t, v, b));
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (!RESET && OUT_VALID && OUT_READY) begin
            logic [32:0] e;
            if (exp_q.size() == 0) begin
                tests++; errors++;
                $display("FAIL unexpected_word: got 0x%08h expected no output", INSTRUCTION);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard_word", INSTRUCTION, e[31:0]);
                check("scoreboard_err", {31'd0, IMM_ERR}, {31'd0, e[32]});
            end
        end
    end

    always @(posedge CLK) begin
        if (random_phase) begin
            #1;
            OUT_READY = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [2:0]  t;
        logic [31:0] v;
        int n;
        RESET = 1'b1; IN_VALID = 1'b0; IMM_TYPE = '0; IMM_VALUE = '0; BASE_INSTR = '0; OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("reset_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("reset_in_ready", {31'd0, IN_READY}, 32'd1);
        check("reset_instruction", INSTRUCTION, 32'd0);
        check("reset_imm_err", {31'd0, IMM_ERR}, 32'd0);
        @(posedge CLK); #1;

        send(3'd0, 32'hFFFFF800, 32'h00000013);
        @(negedge CLK);
        check("latency_out_valid", {31'd0, OUT_VALID}, 32'd1);
        check("i_min_word", INSTRUCTION, 32'h80000013);
        @(posedge CLK); #1;
        send(3'd2, 32'h00000800, 32'h00000063);
        send(3'd3, 32'h12345000, 32'h00000037);
        send(3'd3, 32'h12345001, 32'h00000037);
        send(3'd4, 32'h00000001, 32'h0000006F);
        send(3'd1, 32'h000007FF, 32'hFFFFFFFF);
        send(3'd1, 32'hFFFFF000, 32'h00000023);
        send(3'd2, 32'h00000FFE, 32'h00000063);
        send(3'd2, 32'hFFFFF000, 32'h00000063);
        send(3'd4, 32'h000FFFFE, 32'h0000006F);
        send(3'd4, 32'hFFF00000, 32'h0000006F);
        send(3'd0, 32'h00000800, 32'h00000013);
        send(3'd6, 32'hDEADBEEF, 32'hCAFEF00D);
        repeat (3) @(posedge CLK); #1;

        // Back-pressure: two jobs fill the FIFO, a third must be held off.
        OUT_READY = 1'b0;
        send(3'd0, 32'h00000001, 32'h11111113);
        send(3'd0, 32'h00000002, 32'h22222213);
        IN_VALID = 1'b1; IMM_TYPE = 3'd0; IMM_VALUE = 32'h3; BASE_INSTR = 32'h33333313;
        repeat (3) begin
            @(negedge CLK);
            check("full_in_ready", {31'd0, IN_READY}, 32'd0);
            check("full_out_valid", {31'd0, OUT_VALID}, 32'd1);
        end
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        send(3'd0, 32'h00000003, 32'h33333313);
        repeat (4) @(posedge CLK); #1;

        // Reset with two entries queued discards them.
        OUT_READY = 1'b0;
        send(3'd3, 32'hABCDE000, 32'h00000037);
        send(3'd3, 32'h55555000, 32'h00000037);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        check("flush_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("flush_in_ready", {31'd0, IN_READY}, 32'd1);
        check("flush_instruction", INSTRUCTION, 32'd0);
        check("flush_imm_err", {31'd0, IMM_ERR}, 32'd0);
        OUT_READY = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("flush_stays_empty", {31'd0, OUT_VALID}, 32'd0);
        end
        @(posedge CLK); #1;

        random_phase = 1;
        for (int k = 0; k < 300; k++) begin
            t = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       v = $urandom();
                1:       v = 32'($signed(12'($urandom())));
                2:       v = 32'($signed(21'($urandom())));
                default: v = {$urandom_range(0, 1) ? 20'hFFFFF : 20'h0, 12'($urandom())} & ~32'h1;
            endcase
            send(t, v, $urandom());
            if ($urandom_range(0, 4) == 0) begin
                @(posedge CLK); #1;
            end
        end
        random_phase = 0;
        #1 OUT_READY = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(posedge CLK);
        end
        check("drain_remaining", exp_q.size(), 32'd0);
        repeat (2) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
